// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the MEM-stage
//                load/store interface. Accepts one doubleword request at a
//                time, waits a fixed latency, performs the access, and
//                returns a one-cycle response. It also drives the pipeline
//                stall and exposes the first five words as tap outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [63:0] index0,
    output logic [63:0] index1,
    output logic [63:0] index2,
    output logic [63:0] index3,
    output logic [63:0] index4
);

    localparam int       c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // WAIT counts down to zero, so it is loaded with two less than the latency
    // (one cycle is spent accepting the request and one responding).
    localparam int       c_LOAD_INT = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam bit [3:0] c_CNT_LOAD = 4'(c_LOAD_INT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    // Memory powers up cleared; reset intentionally leaves it untouched.
    logic [63:0] r_mem [DEPTH] = '{default: '0};

    logic [60:0]     w_idx_wide;
    logic [c_AW-1:0] w_idx;
    logic            w_err;
    logic            w_mem_we;

    // Decode the latched address into a word index and an error flag.
    assign w_idx_wide = r_addr[63:3];
    assign w_idx      = w_idx_wide[c_AW-1:0];
    assign w_err      = (r_addr[2:0] != 3'b000) || (w_idx_wide >= 61'(DEPTH));
    assign w_mem_we   = (r_state == S_RESP) && r_write && !w_err;

    // Next-state logic and handshake/response outputs.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                // Stall drops here so the instruction leaves MEM with its data.
                rsp_valid = 1'b1;
                rsp_err   = w_err;
                if (!r_write && !w_err) begin
                    rsp_rdata = r_mem[w_idx];
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, latency counter and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Store commits at the edge ending RESP, before the next request is seen.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // Tap view of the lowest five words.
    assign index0 = r_mem[0];
    assign index1 = r_mem[1];
    assign index2 = r_mem[2];
    assign index3 = r_mem[3];
    assign index4 = r_mem[4];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder using three
//                instances: LATENCY=2 (main), LATENCY=1 (back-to-back) and
//                LATENCY=4 (reset during WAIT).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: LATENCY=2
    logic        rst_a, valid_a, write_a, ready_a, rvalid_a, err_a, stall_a;
    logic [63:0] addr_a, wdata_a, rdata_a, i0_a, i1_a, i2_a, i3_a, i4_a;
    // Instance B: LATENCY=1
    logic        rst_b, valid_b, write_b, ready_b, rvalid_b, err_b, stall_b;
    logic [63:0] addr_b, wdata_b, rdata_b, i0_b, i1_b, i2_b, i3_b, i4_b;
    // Instance C: LATENCY=4
    logic        rst_c, valid_c, write_c, ready_c, rvalid_c, err_c, stall_c;
    logic [63:0] addr_c, wdata_c, rdata_c, i0_c, i1_c, i2_c, i3_c, i4_c;

    dmem_responder #(.DEPTH(32), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(rst_a), .req_valid(valid_a), .req_ready(ready_a),
        .req_write(write_a), .req_addr(addr_a), .req_wdata(wdata_a),
        .rsp_valid(rvalid_a), .rsp_rdata(rdata_a), .rsp_err(err_a), .stall(stall_a),
        .index0(i0_a), .index1(i1_a), .index2(i2_a), .index3(i3_a), .index4(i4_a)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .req_valid(valid_b), .req_ready(ready_b),
        .req_write(write_b), .req_addr(addr_b), .req_wdata(wdata_b),
        .rsp_valid(rvalid_b), .rsp_rdata(rdata_b), .rsp_err(err_b), .stall(stall_b),
        .index0(i0_b), .index1(i1_b), .index2(i2_b), .index3(i3_b), .index4(i4_b)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(4)) u_dut_c (
        .clk(clk), .reset(rst_c), .req_valid(valid_c), .req_ready(ready_c),
        .req_write(write_c), .req_addr(addr_c), .req_wdata(wdata_c),
        .rsp_valid(rvalid_c), .rsp_rdata(rdata_c), .rsp_err(err_c), .stall(stall_c),
        .index0(i0_c), .index1(i1_c), .index2(i2_c), .index3(i3_c), .index4(i4_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on instance A with cycle-exact LATENCY=2 timing.
    task automatic acc_a(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input logic [63:0] exp_rd, input string tag);
        @(negedge clk);
        valid_a = 1'b1; write_a = wr; addr_a = addr; wdata_a = wdata;
        #1;
        chk({tag, " stall_on_req"}, 64'(stall_a), 64'd1);
        chk({tag, " ready_idle"},   64'(ready_a), 64'd1);
        @(negedge clk);
        valid_a = 1'b0;
        #1;
        chk({tag, " stall_wait"},   64'(stall_a),  64'd1);
        chk({tag, " no_rsp_wait"},  64'(rvalid_a), 64'd0);
        chk({tag, " ready_wait"},   64'(ready_a),  64'd0);
        @(negedge clk);
        chk({tag, " rsp_valid"},    64'(rvalid_a), 64'd1);
        chk({tag, " rsp_err"},      64'(err_a),    64'(exp_err));
        chk({tag, " rsp_rdata"},    rdata_a,       exp_rd);
        chk({tag, " stall_resp"},   64'(stall_a),  64'd0);
        chk({tag, " ready_resp"},   64'(ready_a),  64'd0);
        @(negedge clk);
        chk({tag, " rsp_drop"},     64'(rvalid_a), 64'd0);
        chk({tag, " rdata_zero"},   rdata_a,       64'd0);
        chk({tag, " err_zero"},     64'(err_a),    64'd0);
        chk({tag, " ready_back"},   64'(ready_a),  64'd1);
    endtask

    initial begin
        logic seen;
        rst_a = 1'b0; valid_a = 1'b0; write_a = 1'b0; addr_a = '0; wdata_a = '0;
        rst_b = 1'b0; valid_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0;
        rst_c = 1'b0; valid_c = 1'b0; write_c = 1'b0; addr_c = '0; wdata_c = '0;

        // Reset for 3 ns with no request pending
        #1; rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #2;
        chk("reset ready",  64'(ready_a),  64'd1);
        chk("reset rvalid", 64'(rvalid_a), 64'd0);
        chk("reset stall",  64'(stall_a),  64'd0);
        chk("reset rdata",  rdata_a,       64'd0);
        chk("reset err",    64'(err_a),    64'd0);
        chk("reset idx0",   i0_a, 64'd0);
        chk("reset idx1",   i1_a, 64'd0);
        chk("reset idx2",   i2_a, 64'd0);
        chk("reset idx3",   i3_a, 64'd0);
        chk("reset idx4",   i4_a, 64'd0);
        #1; rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Store then load, LATENCY=2
        acc_a(1'b1, 64'h10, 64'hDEADBEEF, 1'b0, 64'd0, "st10");
        chk("st10 idx2", i2_a, 64'hDEADBEEF);
        acc_a(1'b0, 64'h10, 64'd0, 1'b0, 64'hDEADBEEF, "ld10");

        // Misaligned load and store
        acc_a(1'b0, 64'h0C, 64'd0, 1'b1, 64'd0, "ld0C");
        acc_a(1'b1, 64'h0C, 64'h1234, 1'b1, 64'd0, "st0C");
        chk("st0C idx1", i1_a, 64'd0);
        chk("st0C idx2", i2_a, 64'hDEADBEEF);

        // Out of range store
        acc_a(1'b1, 64'h100, 64'hAA, 1'b1, 64'd0, "st100");
        chk("st100 idx0", i0_a, 64'd0);
        chk("st100 idx1", i1_a, 64'd0);
        chk("st100 idx2", i2_a, 64'hDEADBEEF);
        chk("st100 idx3", i3_a, 64'd0);
        chk("st100 idx4", i4_a, 64'd0);

        // Edge addresses: word 4, last legal word, word 0
        acc_a(1'b1, 64'h20, 64'h55, 1'b0, 64'd0, "st20");
        chk("st20 idx4", i4_a, 64'h55);
        chk("st20 idx3", i3_a, 64'd0);
        acc_a(1'b0, 64'h20, 64'd0, 1'b0, 64'h55, "ld20");
        acc_a(1'b1, 64'hF8, 64'h0123456789ABCDEF, 1'b0, 64'd0, "stF8");
        acc_a(1'b0, 64'hF8, 64'd0, 1'b0, 64'h0123456789ABCDEF, "ldF8");
        acc_a(1'b0, 64'h0, 64'd0, 1'b0, 64'd0, "ld00");

        // LATENCY=1: prime word 1, then two loads with req_valid held
        @(negedge clk);
        valid_b = 1'b1; write_b = 1'b1; addr_b = 64'h08; wdata_b = 64'h77;
        @(negedge clk);
        chk("b st rvalid", 64'(rvalid_b), 64'd1);
        chk("b st err",    64'(err_b),    64'd0);
        valid_b = 1'b0;
        @(negedge clk);
        chk("b st idx1", i1_b, 64'h77);
        valid_b = 1'b1; write_b = 1'b0; addr_b = 64'h08;
        @(negedge clk);
        chk("b ld1 rvalid", 64'(rvalid_b), 64'd1);
        chk("b ld1 rdata",  rdata_b,       64'h77);
        chk("b ld1 ready",  64'(ready_b),  64'd0);
        chk("b ld1 stall",  64'(stall_b),  64'd0);
        addr_b = 64'h09;
        @(negedge clk);
        chk("b gap rvalid", 64'(rvalid_b), 64'd0);
        chk("b gap ready",  64'(ready_b),  64'd1);
        chk("b gap stall",  64'(stall_b),  64'd1);
        @(negedge clk);
        chk("b ld2 rvalid", 64'(rvalid_b), 64'd1);
        chk("b ld2 err",    64'(err_b),    64'd1);
        chk("b ld2 rdata",  rdata_b,       64'd0);
        chk("b ld2 ready",  64'(ready_b),  64'd0);
        valid_b = 1'b0;
        @(negedge clk);
        chk("b end rvalid", 64'(rvalid_b), 64'd0);

        // LATENCY=4: reset one cycle after accepting a store
        @(negedge clk);
        valid_c = 1'b1; write_c = 1'b1; addr_c = 64'h08; wdata_c = 64'd5;
        @(negedge clk);
        valid_c = 1'b0;
        #1;
        chk("c wait stall", 64'(stall_c), 64'd1);
        @(posedge clk);
        #1; rst_c = 1'b1;
        #1;
        chk("c rst ready",  64'(ready_c),  64'd1);
        chk("c rst stall",  64'(stall_c),  64'd0);
        chk("c rst rvalid", 64'(rvalid_c), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_c = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid_c) seen = 1'b1;
        end
        chk("c no rsp",    64'(seen),    64'd0);
        chk("c idx1",      i1_c,         64'd0);
        chk("c ready end", 64'(ready_c), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined RISC-V core: the memory-side end of the MEM-stage load/store interface. Accepts one 64-bit doubleword request at a time over a valid/ready handshake, waits a fixed programmable latency, performs the access, and returns read data or an error with a one-cycle response pulse. Drives a stall signal into the hazard detection unit so the pipeline freezes while an access is outstanding. Exposes the first five memory words for the same tap-style observation the core already provides.

## Interface
- DEPTH, 32, number of 64-bit words; legal byte addresses are 0 .. 8*DEPTH-1
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears control state
- req_valid  input  1  MEM stage presents a request (MemRead or MemWrite asserted)
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store (MemWrite), 0 = load (MemRead)
- req_addr  input  64  byte address (ALU Result)
- req_wdata  input  64  store data (ReadData2 path)
- rsp_valid  output  1  one-cycle pulse: access complete
- rsp_rdata  output  64  load data, valid with rsp_valid
- rsp_err  output  1  misaligned or out-of-range access, valid with rsp_valid
- stall  output  1  freeze PC/IF/ID/EX/MEM registers
- index0..index4  output  64 each  continuous view of mem[0]..mem[4]

## Operation
- Clock is clk; reset is asynchronous and active-high.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch write flag, address, wdata; go to RESP if LATENCY=1, else WAIT with counter loaded to LATENCY-2.
- WAIT: req_ready=0; decrement counter; at 0 go to RESP. Request inputs ignored.
- RESP: req_ready=0; rsp_valid=1; access performed on the latched request; next state IDLE.
- Word index = addr[63:3]. Error if addr[2:0]!=0 or index>=DEPTH.
- Load, no error: rsp_rdata=mem[index], rsp_err=0.
- Store, no error: mem[index]<=wdata at the end of RESP cycle; rsp_rdata=0.
- Any error: rsp_err=1, rsp_rdata=0, memory unchanged.
- rsp_rdata and rsp_err are 0 whenever rsp_valid=0.
- stall = (state==WAIT) | (state==IDLE & req_valid); 0 in RESP so the instruction leaves MEM with its data.
- Memory contents initialised to zero at time zero; reset does NOT clear memory.
- index0..index4 combinationally reflect stored contents (updated after the store edge).

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0; stall follows req_valid.
- Request accepted at edge k (IDLE & req_valid) -> rsp_valid high in the cycle after edge k+LATENCY-1; total LATENCY cycles after acceptance.
- Next request accepted no earlier than the edge ending RESP; minimum issue interval LATENCY+1 cycles.
- stall high for LATENCY cycles per access (acceptance cycle plus WAIT cycles).
- Store-then-load to same address: load sees stored value (store commits before IDLE).
- Reset asserted in WAIT or RESP: return to IDLE immediately; pending access dropped, no memory write, no rsp_valid.
- req_valid deasserted during WAIT: has no effect; access completes.

## Test plan
- Reset: hold reset 3 ns with req_valid=0 -> req_ready=1, rsp_valid=0, stall=0, index0..4=0.
- Store then load, LATENCY=2: store addr 0x10 data 0xDEADBEEF -> rsp_valid exactly 2 cycles after acceptance, rsp_err=0, index2=0xDEADBEEF; load addr 0x10 -> rsp_rdata=0xDEADBEEF, stall high 2 cycles.
- Misaligned: load addr 0x0C -> rsp_err=1, rsp_rdata=0; store addr 0x0C -> memory unchanged.
- Out of range, DEPTH=32: store addr 0x100 -> rsp_err=1, index0..4 unchanged.
- LATENCY=1 back-to-back: two loads held on req_valid -> responses 2 cycles apart, req_ready low in RESP cycle.
- Reset mid-WAIT (LATENCY=4): store to 0x08 value 5, assert reset one cycle after acceptance -> no rsp_valid, index1 stays 0, req_ready=1.
